// File: rtl/spi_responder.sv
// SPI mode-0 slave emulating a 64 x 8 accelerometer register map.
// Handles 3-byte command frames (read 0x0B / write 0x0A) with burst auto-increment.
module spi_responder (
    input  logic       clk,
    input  logic       reset,
    input  logic       CS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [7:0] x_data,
    input  logic [7:0] y_data,
    input  logic [7:0] z_data,
    output logic       wr_strobe,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       active
);

    localparam logic [7:0] CMD_WRITE = 8'h0A;
    localparam logic [7:0] CMD_READ  = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_IGNORE
    } state_t;

    state_t      state_reg, state_next;

    // [0],[1] are the synchronizer flops, [2] holds the previous synchronized value.
    // CS resets low so a CS already low at release cannot produce a falling edge.
    logic [2:0]  cs_pipe_reg;
    logic [2:0]  sclk_pipe_reg;
    logic [1:0]  mosi_pipe_reg;

    logic [7:0]  rx_shift_reg;
    logic [2:0]  bitcnt_reg;
    logic [5:0]  addr_reg;
    logic        is_write_reg;
    logic [7:0]  tx_shift_reg;
    logic        skip_fall_reg;
    logic        miso_reg;
    logic        wr_strobe_reg;
    logic [5:0]  wr_addr_reg;
    logic [7:0]  wr_data_reg;
    logic [7:0]  rw_mem_reg [0:47];

    logic        cs_fall, cs_rise, sclk_rise, sclk_fall, mosi_bit;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic        mem_we;
    logic [5:0]  load_addr;
    logic [5:0]  rd_idx;
    logic [5:0]  wr_idx;
    logic [7:0]  load_data;

    assign cs_fall   = cs_pipe_reg[2] & ~cs_pipe_reg[1];
    assign cs_rise   = ~cs_pipe_reg[2] & cs_pipe_reg[1];
    assign sclk_rise = ~sclk_pipe_reg[2] & sclk_pipe_reg[1];
    assign sclk_fall = sclk_pipe_reg[2] & ~sclk_pipe_reg[1];
    assign mosi_bit  = mosi_pipe_reg[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_pipe_reg   <= 3'b000;
            sclk_pipe_reg <= 3'b000;
            mosi_pipe_reg <= 2'b00;
        end else begin
            cs_pipe_reg   <= {cs_pipe_reg[1:0], CS};
            sclk_pipe_reg <= {sclk_pipe_reg[1:0], SCLK};
            mosi_pipe_reg <= {mosi_pipe_reg[0], MOSI};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        rx_byte    = {rx_shift_reg[6:0], mosi_bit};
        byte_done  = (state_reg != ST_IDLE) && sclk_rise && (bitcnt_reg == 3'd7);
        mem_we     = (state_reg == ST_DATA) && is_write_reg && byte_done &&
                     (addr_reg >= 6'h10) && !cs_rise;
        case (state_reg)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_READ || rx_byte == CMD_WRITE) begin
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_IGNORE;
                    end
                end
            end
            ST_ADDR: begin
                if (byte_done) begin
                    state_next = ST_DATA;
                end
            end
            default: state_next = state_reg;
        endcase
        if (cs_rise) begin
            state_next = ST_IDLE;
        end
    end

    // Byte to load into the TX shifter: the freshly received address, or the next burst address.
    always_comb begin
        load_addr = (state_reg == ST_ADDR) ? rx_byte[5:0] : addr_reg + 6'd1;
        rd_idx    = load_addr - 6'd16;
        wr_idx    = addr_reg - 6'd16;
        case (load_addr)
            6'h00:   load_data = 8'hAD;
            6'h01:   load_data = 8'h1D;
            6'h02:   load_data = 8'hF2;
            6'h08:   load_data = x_data;
            6'h09:   load_data = y_data;
            6'h0A:   load_data = z_data;
            default: load_data = (load_addr >= 6'h10) ? rw_mem_reg[rd_idx] : 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_shift_reg  <= 8'h00;
            bitcnt_reg    <= 3'd0;
            addr_reg      <= 6'd0;
            is_write_reg  <= 1'b0;
            tx_shift_reg  <= 8'h00;
            skip_fall_reg <= 1'b0;
            miso_reg      <= 1'b0;
            wr_strobe_reg <= 1'b0;
            wr_addr_reg   <= 6'd0;
            wr_data_reg   <= 8'h00;
        end else begin
            wr_strobe_reg <= 1'b0;
            if (cs_rise || state_reg == ST_IDLE) begin
                rx_shift_reg  <= 8'h00;
                bitcnt_reg    <= 3'd0;
                skip_fall_reg <= 1'b0;
                miso_reg      <= 1'b0;
            end else begin
                if (sclk_rise) begin
                    rx_shift_reg <= rx_byte;
                    bitcnt_reg   <= bitcnt_reg + 3'd1;
                end
                case (state_reg)
                    ST_CMD: begin
                        if (byte_done) begin
                            is_write_reg <= (rx_byte == CMD_WRITE);
                        end
                    end
                    ST_ADDR: begin
                        if (byte_done) begin
                            addr_reg <= rx_byte[5:0];
                            if (!is_write_reg) begin
                                tx_shift_reg  <= load_data;
                                miso_reg      <= load_data[7];
                                skip_fall_reg <= 1'b1;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (is_write_reg) begin
                            if (byte_done) begin
                                if (mem_we) begin
                                    wr_strobe_reg <= 1'b1;
                                    wr_addr_reg   <= addr_reg;
                                    wr_data_reg   <= rx_byte;
                                end
                                addr_reg <= addr_reg + 6'd1;
                            end
                        end else if (byte_done) begin
                            addr_reg      <= addr_reg + 6'd1;
                            tx_shift_reg  <= load_data;
                            miso_reg      <= load_data[7];
                            skip_fall_reg <= 1'b1;
                        end else if (sclk_fall) begin
                            // The falling edge right after a load must keep the MSB on the wire.
                            if (skip_fall_reg) begin
                                skip_fall_reg <= 1'b0;
                            end else begin
                                tx_shift_reg <= {tx_shift_reg[6:0], 1'b0};
                                miso_reg     <= tx_shift_reg[6];
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 48; i++) begin
                rw_mem_reg[i] <= 8'h00;
            end
        end else if (mem_we) begin
            rw_mem_reg[wr_idx] <= rx_byte;
        end
    end

    assign MISO      = miso_reg;
    assign wr_strobe = wr_strobe_reg;
    assign wr_addr   = wr_addr_reg;
    assign wr_data   = wr_data_reg;
    assign active    = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: bit-banged SPI mode-0 master with hand-computed expectations.
module tb_spi_responder;

    logic       clk;
    logic       reset;
    logic       CS;
    logic       SCLK;
    logic       MOSI;
    logic       MISO;
    logic [7:0] x_data, y_data, z_data;
    logic       wr_strobe;
    logic [5:0] wr_addr;
    logic [7:0] wr_data;
    logic       active;

    int n_vec  = 0;
    int n_miss = 0;
    int strobe_cycles = 0;
    logic [5:0] last_wa = 6'd0;
    logic [7:0] last_wd = 8'd0;

    logic [7:0] tx_b [0:7];
    logic [7:0] rx_b [0:7];

    spi_responder dut (
        .clk       (clk),
        .reset     (reset),
        .CS        (CS),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .x_data    (x_data),
        .y_data    (y_data),
        .z_data    (z_data),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .active    (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each clock with wr_strobe high is counted, so a stretched pulse shows as extra cycles.
    always @(posedge clk) begin
        if (wr_strobe === 1'b1) begin
            strobe_cycles <= strobe_cycles + 1;
            last_wa       <= wr_addr;
            last_wd       <= wr_data;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int k = 0; k < nb; k++) begin
            MOSI = tx[7-k];
            wait_clk(8);
            rx[7-k] = MISO;
            SCLK = 1'b1;
            wait_clk(8);
            SCLK = 1'b0;
        end
    endtask

    task automatic set_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                          input logic [7:0] d, input logic [7:0] e);
        tx_b[0] = a; tx_b[1] = b; tx_b[2] = c; tx_b[3] = d; tx_b[4] = e;
    endtask

    task automatic do_frame(input int nbytes);
        logic [7:0] r;
        CS = 1'b0;
        wait_clk(8);
        for (int b = 0; b < nbytes; b++) begin
            send_bits(tx_b[b], 8, r);
            rx_b[b] = r;
        end
        wait_clk(8);
        CS = 1'b1;
        wait_clk(12);
        $display("frame %0d bytes: tx %h %h %h %h %h  rx %h %h %h %h %h", nbytes,
                 tx_b[0], tx_b[1], tx_b[2], tx_b[3], tx_b[4],
                 rx_b[0], rx_b[1], rx_b[2], rx_b[3], rx_b[4]);
    endtask

    task automatic test_reset;
        reset = 1'b0; CS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
        wait_clk(3);
        n_vec++; if (MISO !== 1'b0)      begin n_miss++; $display("FAIL reset_miso got %b want 0", MISO); end
        n_vec++; if (active !== 1'b0)    begin n_miss++; $display("FAIL reset_active got %b want 0", active); end
        n_vec++; if (wr_strobe !== 1'b0) begin n_miss++; $display("FAIL reset_strobe got %b want 0", wr_strobe); end
        n_vec++; if (wr_addr !== 6'd0)   begin n_miss++; $display("FAIL reset_wr_addr got %h want 00", wr_addr); end
        n_vec++; if (wr_data !== 8'd0)   begin n_miss++; $display("FAIL reset_wr_data got %h want 00", wr_data); end
        reset = 1'b1;
        wait_clk(6);
    endtask

    task automatic test_active;
        CS = 1'b0;
        wait_clk(2);
        n_vec++; if (active !== 1'b0) begin n_miss++; $display("FAIL active_rise_early got %b want 0", active); end
        wait_clk(1);
        n_vec++; if (active !== 1'b1) begin n_miss++; $display("FAIL active_rise got %b want 1", active); end
        wait_clk(5);
        CS = 1'b1;
        wait_clk(2);
        n_vec++; if (active !== 1'b1) begin n_miss++; $display("FAIL active_fall_early got %b want 1", active); end
        wait_clk(1);
        n_vec++; if (active !== 1'b0) begin n_miss++; $display("FAIL active_fall got %b want 0", active); end
        wait_clk(8);
    endtask

    task automatic test_read_id;
        int snap;
        snap = strobe_cycles;
        set_tx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if ({rx_b[0], rx_b[1], rx_b[2]} !== 24'h0000AD)
            begin n_miss++; $display("FAIL read_id got %h want 0000ad", {rx_b[0], rx_b[1], rx_b[2]}); end
        n_vec++; if (strobe_cycles - snap !== 0)
            begin n_miss++; $display("FAIL read_id_strobe got %0d want 0", strobe_cycles - snap); end
    endtask

    task automatic test_write;
        int snap;
        snap = strobe_cycles;
        set_tx(8'h0A, 8'h2D, 8'h02, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if (strobe_cycles - snap !== 1)
            begin n_miss++; $display("FAIL write_strobe got %0d want 1", strobe_cycles - snap); end
        n_vec++; if (last_wa !== 6'h2D) begin n_miss++; $display("FAIL write_addr got %h want 2d", last_wa); end
        n_vec++; if (last_wd !== 8'h02) begin n_miss++; $display("FAIL write_data got %h want 02", last_wd); end
        n_vec++; if (wr_addr !== 6'h2D || wr_data !== 8'h02)
            begin n_miss++; $display("FAIL write_hold got %h/%h want 2d/02", wr_addr, wr_data); end
        set_tx(8'h0B, 8'h2D, 8'h00, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if ({rx_b[0], rx_b[1], rx_b[2]} !== 24'h000002)
            begin n_miss++; $display("FAIL write_readback got %h want 000002", {rx_b[0], rx_b[1], rx_b[2]}); end
    endtask

    task automatic test_burst;
        x_data = 8'h12; y_data = 8'h34; z_data = 8'h56;
        set_tx(8'h0B, 8'h08, 8'h00, 8'h00, 8'h00);
        do_frame(5);
        n_vec++; if ({rx_b[2], rx_b[3], rx_b[4]} !== 24'h123456)
            begin n_miss++; $display("FAIL burst_xyz got %h want 123456", {rx_b[2], rx_b[3], rx_b[4]}); end
        n_vec++; if ({rx_b[0], rx_b[1]} !== 16'h0000)
            begin n_miss++; $display("FAIL burst_hdr_miso got %h want 0000", {rx_b[0], rx_b[1]}); end
        set_tx(8'h0A, 8'h3F, 8'h77, 8'h00, 8'h00);
        do_frame(3);
        set_tx(8'h0B, 8'h3F, 8'h00, 8'h00, 8'h00);
        do_frame(4);
        n_vec++; if ({rx_b[2], rx_b[3]} !== 16'h77AD)
            begin n_miss++; $display("FAIL burst_wrap got %h want 77ad", {rx_b[2], rx_b[3]}); end
    endtask

    task automatic test_write_ro;
        int snap;
        snap = strobe_cycles;
        set_tx(8'h0A, 8'h00, 8'h55, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if (strobe_cycles - snap !== 0)
            begin n_miss++; $display("FAIL ro_strobe got %0d want 0", strobe_cycles - snap); end
        set_tx(8'h0B, 8'h00, 8'h00, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if (rx_b[2] !== 8'hAD) begin n_miss++; $display("FAIL ro_readback got %h want ad", rx_b[2]); end
        snap = strobe_cycles;
        set_tx(8'h0A, 8'h3F, 8'h11, 8'h22, 8'h00);
        do_frame(4);
        n_vec++; if (strobe_cycles - snap !== 1)
            begin n_miss++; $display("FAIL wrap_write_strobe got %0d want 1", strobe_cycles - snap); end
        n_vec++; if (last_wa !== 6'h3F || last_wd !== 8'h11)
            begin n_miss++; $display("FAIL wrap_write got %h/%h want 3f/11", last_wa, last_wd); end
        set_tx(8'h0B, 8'h3F, 8'h00, 8'h00, 8'h00);
        do_frame(4);
        n_vec++; if ({rx_b[2], rx_b[3]} !== 16'h11AD)
            begin n_miss++; $display("FAIL wrap_write_readback got %h want 11ad", {rx_b[2], rx_b[3]}); end
    endtask

    task automatic test_ignore;
        int snap;
        logic [7:0] r;
        snap = strobe_cycles;
        set_tx(8'h55, 8'hFF, 8'hFF, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if ({rx_b[0], rx_b[1], rx_b[2]} !== 24'h000000)
            begin n_miss++; $display("FAIL ignore_miso got %h want 000000", {rx_b[0], rx_b[1], rx_b[2]}); end
        n_vec++; if (strobe_cycles - snap !== 0)
            begin n_miss++; $display("FAIL ignore_strobe got %0d want 0", strobe_cycles - snap); end
        CS = 1'b0;
        wait_clk(8);
        send_bits(8'h0A, 8, r);
        send_bits(8'h20, 8, r);
        send_bits(8'hFF, 4, r);
        wait_clk(8);
        CS = 1'b1;
        wait_clk(12);
        $display("frame partial: tx 0a 20 f(4 bits)");
        n_vec++; if (strobe_cycles - snap !== 0)
            begin n_miss++; $display("FAIL partial_strobe got %0d want 0", strobe_cycles - snap); end
        set_tx(8'h0B, 8'h20, 8'h00, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if (rx_b[2] !== 8'h00) begin n_miss++; $display("FAIL partial_readback got %h want 00", rx_b[2]); end
    endtask

    task automatic test_reset_midburst;
        logic [7:0] r;
        set_tx(8'h0A, 8'h30, 8'h99, 8'h00, 8'h00);
        do_frame(3);
        CS = 1'b0;
        wait_clk(8);
        send_bits(8'h0B, 8, r);
        send_bits(8'h30, 8, r);
        send_bits(8'h00, 3, r);
        n_vec++; if (r[7:5] !== 3'b100) begin n_miss++; $display("FAIL midburst_bits got %b want 100", r[7:5]); end
        wait_clk(4);
        // 0x99 shifted three times leaves bit 4 (a one) on MISO.
        n_vec++; if (MISO !== 1'b1) begin n_miss++; $display("FAIL midburst_miso got %b want 1", MISO); end
        reset = 1'b0;
        #1;
        n_vec++; if (MISO !== 1'b0)   begin n_miss++; $display("FAIL async_reset_miso got %b want 0", MISO); end
        n_vec++; if (active !== 1'b0) begin n_miss++; $display("FAIL async_reset_active got %b want 0", active); end
        wait_clk(3);
        reset = 1'b1;
        wait_clk(10);
        send_bits(8'h0B, 8, r);
        n_vec++; if (active !== 1'b0) begin n_miss++; $display("FAIL cs_low_release got %b want 0", active); end
        CS = 1'b1;
        wait_clk(12);
        $display("frame aborted by reset, then cs held low across release");
        set_tx(8'h0B, 8'h30, 8'h00, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if (rx_b[2] !== 8'h00) begin n_miss++; $display("FAIL post_reset_30 got %h want 00", rx_b[2]); end
        set_tx(8'h0B, 8'h2D, 8'h00, 8'h00, 8'h00);
        do_frame(3);
        n_vec++; if (rx_b[2] !== 8'h00) begin n_miss++; $display("FAIL post_reset_2d got %h want 00", rx_b[2]); end
        set_tx(8'h0B, 8'h3F, 8'h00, 8'h00, 8'h00);
        do_frame(4);
        n_vec++; if ({rx_b[2], rx_b[3]} !== 16'h00AD)
            begin n_miss++; $display("FAIL post_reset_3f got %h want 00ad", {rx_b[2], rx_b[3]}); end
    endtask

    initial begin
        x_data = 8'h00; y_data = 8'h00; z_data = 8'h00;
        for (int i = 0; i < 8; i++) begin
            tx_b[i] = 8'h00;
            rx_b[i] = 8'h00;
        end
        test_reset;
        test_active;
        test_read_id;
        test_write;
        test_burst;
        test_write_ro;
        test_ignore;
        test_reset_midburst;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/spi_responder.md
# spi_responder

SPI mode-0 slave that answers the 3-byte command frames issued by the team's SPI master path (command, address, data). It emulates the accelerometer register interface: 64 × 8 register map, register read (0x0B) and register write (0x0A), burst auto-increment, and live X/Y/Z sample registers fed from fabric. Its main use is as a synthesizable sensor stand-in and protocol peer for closed-loop tests of the SPI controller and command driver, and it can also be placed on a board.

## Interface
Parameters: none. Register map and timing are fixed.

Ports:
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- CS  input  1  chip select, active low, asynchronous to clk
- SCLK  input  1  SPI clock from master, idle low
- MOSI  input  1  master-to-slave data
- MISO  output  1  slave-to-master data; 0 whenever not transmitting
- x_data, y_data, z_data  input  8 each  sample values returned at addresses 0x08, 0x09, 0x0A
- wr_strobe  output  1  one-clk pulse per accepted register write
- wr_addr  output  6  address of the last accepted write
- wr_data  output  8  data of the last accepted write
- active  output  1  high while a frame is in progress (CS low and seen by synchronizer)

## Operation
- CS, SCLK and MOSI each pass through a 2-flop synchronizer. Edges are detected on the synchronized copies.
- Register map:
  - 0x00 = 0xAD, 0x01 = 0x1D, 0x02 = 0xF2, all read-only.
  - 0x03–0x07 and 0x0B–0x0F read 0x00 and are read-only.
  - 0x08/0x09/0x0A are read-only and return x/y/z_data, sampled when the byte is loaded into the TX shifter.
  - 0x10–0x3F are read/write with reset value 0x00.
  - Address bits [7:6] are ignored.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE → CMD on CS falling edge. bitcnt=0, MISO=0.
  - Each SCLK rising edge (CS low) shifts MOSI into rx_shift MSB-first and increments the 3-bit bitcnt. A byte is complete on the 8th rising edge.
  - CMD complete: 0x0B → ADDR (read). 0x0A → ADDR (write). Any other value → IGNORE.
  - ADDR complete: latch addr. For a read, load tx_shift with reg[addr] and drive MISO=tx_shift[7]. Go to DATA.
  - DATA, read: at each SCLK falling edge except the first one after a load, shift tx_shift left and drive the new MSB. At each byte completion, addr ← addr+1 (wraps 0x3F→0x00) and tx_shift is reloaded from the new addr.
  - DATA, write: at each byte completion, if addr ≥ 0x10, write reg[addr], pulse wr_strobe, and update wr_addr/wr_data. Otherwise discard the byte with no strobe. Then addr ← addr+1 (wraps).
  - IGNORE: consume bits with MISO=0 and no writes.
  - CS rising edge in any state → IDLE. Any partial byte is discarded, no write occurs, and MISO=0.
- MISO is 0 during the CMD and ADDR bytes and in IDLE/IGNORE.

## Timing
- Reset (reset=0): state=IDLE, MISO=0, wr_strobe=0, wr_addr=0, wr_data=0, active=0, and the register map returns to its reset values. This applies immediately and mid-frame.
- After reset release, a new CS falling edge is required. If CS is already low at release, it is ignored until CS goes high and then low again.
- Pin-to-action latency is 3 clk (2 synchronizer flops + edge register).
- MISO changes ≤4 clk after the SCLK falling edge, or after the 8th ADDR/DATA rising edge on a load.
- The master must hold SCLK high and low for ≥5 clk each, and CS low ≥5 clk before the first SCLK rising edge.
- wr_strobe is high for exactly 1 clk, 3–4 clk after the 8th rising edge of the data byte. wr_addr/wr_data are valid in the same cycle and held afterwards.
- active rises 3 clk after CS falls and drops 3 clk after CS rises.
- A CS rise that coincides with the 8th SCLK rise is not allowed; the master guarantees ≥5 clk separation.

## Test plan
- Reset then read frame 0x0B,0x00,0x00 → 24-bit MISO capture = 0x0000AD, and wr_strobe stays 0.
- Write frame 0x0A,0x2D,0x02 → exactly one wr_strobe with wr_addr=0x2D, wr_data=0x02. A following read 0x0B,0x2D,0x00 returns 0x000002.
- x=0x12, y=0x34, z=0x56, then a 5-byte burst 0x0B,0x08,xx,xx,xx → data bytes 0x12,0x34,0x56. A burst from 0x3F returns reg[0x3F] then 0xAD (wrap).
- Write 0x0A,0x00,0x55 → no strobe, and read of 0x00 still returns 0xAD. A 4-byte write 0x0A,0x3F,0x11,0x22 → one strobe (0x3F, 0x11) only, because the wrapped byte to 0x00 is ignored.
- Unknown command 0x55 followed by 2 bytes → MISO=0 throughout, no strobe. CS raised after 4 bits of a write data byte → no strobe and the register is unchanged.
- Assert reset mid-burst read → MISO=0 and active=0 immediately. Registers 0x10–0x3F read back 0x00 after release.
